id_ex_stage: RTL and testbench

- ID/EX pipeline register plus load-use hazard detection for the 5-stage RV32I core.
- Captures decoded ID-stage fields each cycle and presents them to EX. This includes rs1/rs2, which the forwarding unit compares against EX/MEM and MEM/WB rd.
- Detects a load in EX whose rd is needed by the instruction in ID; the forwarding unit cannot cover that case. On detection, stalls PC/IF_ID and inserts a bubble.
- Handles downstream freeze (hold) and branch flush.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/load_use_detect.sv | 37 +++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------------+
// | riscv_pkg: shared types and constants for the ID/EX stage of the RV32I  |
// | core. Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

  localparam int RV_XLEN    = 32;
  localparam int RV_ALUOP_W = 4;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    from_ALU     = 2'd0,
    from_DataMem = 2'd1,
    from_PC4     = 2'd2
  } MReg_sel_e;

  // Field widths follow RV_XLEN/RV_ALUOP_W; instantiate id_ex_stage with matching XLEN/ALUOP_W.
  typedef struct packed {
    logic                  valid;
    logic [RV_XLEN-1:0]    pc;
    reg_idx_t              rs1;
    reg_idx_t              rs2;
    reg_idx_t              rd;
    logic [RV_XLEN-1:0]    rs1_data;
    logic [RV_XLEN-1:0]    rs2_data;
    logic [RV_XLEN-1:0]    imm;
    logic [RV_ALUOP_W-1:0] alu_op;
    logic                  alusrc;
    logic                  regwrite;
    logic                  memwrite;
    MReg_sel_e             mreg;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:    1'b0,
    pc:       '0,
    rs1:      5'd0,
    rs2:      5'd0,
    rd:       5'd0,
    rs1_data: '0,
    rs2_data: '0,
    imm:      '0,
    alu_op:   '0,
    alusrc:   1'b0,
    regwrite: 1'b0,
    memwrite: 1'b0,
    mreg:     from_ALU
  };

  // Kills the control and register-index fields; datapath fields are left as they were.
  function automatic id_ex_t insert_bubble(input id_ex_t cur);
    id_ex_t res;
    res          = cur;
    res.valid    = ID_EX_BUBBLE.valid;
    res.regwrite = ID_EX_BUBBLE.regwrite;
    res.memwrite = ID_EX_BUBBLE.memwrite;
    res.rs1      = ID_EX_BUBBLE.rs1;
    res.rs2      = ID_EX_BUBBLE.rs2;
    res.rd       = ID_EX_BUBBLE.rd;
    res.mreg     = ID_EX_BUBBLE.mreg;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// +--------------------------------------------------------------------------+
// | load_use_detect: combinational load-use hazard and ID stall generation. |
// | Revision: 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module load_use_detect
  import riscv_pkg::*;
(
  input  logic      ex_valid,
  input  logic      ex_regwrite,
  input  MReg_sel_e ex_MReg,
  input  reg_idx_t  ex_rd,
  input  logic      id_valid,
  input  logic      id_uses_rs1,
  input  logic      id_uses_rs2,
  input  reg_idx_t  id_rs1,
  input  reg_idx_t  id_rs2,
  input  logic      ex_flush,
  input  logic      hold,
  output logic      lu_haz,
  output logic      stall_id
);

  logic w_ex_is_load;
  logic w_src_match;

  assign w_ex_is_load = ex_valid & ex_regwrite & (ex_MReg == from_DataMem) & (ex_rd != 5'd0);
  assign w_src_match  = (id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd));

  assign lu_haz   = w_ex_is_load & id_valid & w_src_match;
  // A frozen pipeline already stalls upstream; a flush discards the dependent instruction.
  assign stall_id = lu_haz & ~ex_flush & ~hold;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with load-use bubble insertion.    |
// | Optional perf counters when ID_EX_PERF_CNT_EN is defined. Revision: 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               ex_flush,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  reg_idx_t           id_rs1,
  input  reg_idx_t           id_rs2,
  input  reg_idx_t           id_rd,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_alusrc,
  input  logic               id_regwrite,
  input  logic               id_memwrite,
  input  MReg_sel_e          id_MReg,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output reg_idx_t           ex_rs1,
  output reg_idx_t           ex_rs2,
  output reg_idx_t           ex_rd,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_alusrc,
  output logic               ex_regwrite,
  output logic               ex_memwrite,
  output MReg_sel_e          ex_MReg,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        perf_lu_stalls,
  output logic [31:0]        perf_flushes,
`endif
  output logic               stall_id
);

  id_ex_t r_q;
  id_ex_t w_load;
  id_ex_t w_d;
  logic   w_lu_haz;

  load_use_detect u_lu_detect (
    .ex_valid    (r_q.valid),
    .ex_regwrite (r_q.regwrite),
    .ex_MReg     (r_q.mreg),
    .ex_rd       (r_q.rd),
    .id_valid    (id_valid),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_flush    (ex_flush),
    .hold        (hold),
    .lu_haz      (w_lu_haz),
    .stall_id    (stall_id)
  );

  always_comb begin
    w_load          = ID_EX_BUBBLE;
    w_load.valid    = id_valid;
    w_load.pc       = id_pc;
    w_load.rs1      = id_rs1;
    w_load.rs2      = id_rs2;
    w_load.rd       = id_rd;
    w_load.rs1_data = id_rs1_data;
    w_load.rs2_data = id_rs2_data;
    w_load.imm      = id_imm;
    w_load.alu_op   = id_alu_op;
    w_load.alusrc   = id_alusrc;
    w_load.regwrite = id_regwrite & id_valid;
    w_load.memwrite = id_memwrite & id_valid;
    w_load.mreg     = id_MReg;
  end

  always_comb begin
    w_d = w_load;
    if (ex_flush || w_lu_haz) begin
      w_d = insert_bubble(r_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= ID_EX_BUBBLE;
    end else if (!hold) begin
      r_q <= w_d;
    end
  end

  assign ex_valid    = r_q.valid;
  assign ex_pc       = r_q.pc;
  assign ex_rs1      = r_q.rs1;
  assign ex_rs2      = r_q.rs2;
  assign ex_rd       = r_q.rd;
  assign ex_rs1_data = r_q.rs1_data;
  assign ex_rs2_data = r_q.rs2_data;
  assign ex_imm      = r_q.imm;
  assign ex_alu_op   = r_q.alu_op;
  assign ex_alusrc   = r_q.alusrc;
  assign ex_regwrite = r_q.regwrite;
  assign ex_memwrite = r_q.memwrite;
  assign ex_MReg     = r_q.mreg;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_fl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_lu <= 32'd0;
      r_perf_fl <= 32'd0;
    end else if (!hold) begin
      if (w_lu_haz && !ex_flush) r_perf_lu <= r_perf_lu + 32'd1;
      if (ex_flush)              r_perf_fl <= r_perf_fl + 32'd1;
    end
  end

  assign perf_lu_stalls = r_perf_lu;
  assign perf_flushes   = r_perf_fl;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage: directed and randomized checks of id_ex_stage against a |
// | cycle-level reference model. Revision: 1.0                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst, hold, ex_flush, id_valid, id_uses_rs1, id_uses_rs2;
  logic id_alusrc, id_regwrite, id_memwrite;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  reg_idx_t id_rs1, id_rs2, id_rd;
  logic [3:0] id_alu_op;
  MReg_sel_e id_MReg;

  logic ex_valid, ex_alusrc, ex_regwrite, ex_memwrite, stall_id;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  reg_idx_t ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_alu_op;
  MReg_sel_e ex_MReg;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_lu_stalls, perf_flushes;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .hold(hold), .ex_flush(ex_flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_memwrite(id_memwrite), .id_MReg(id_MReg),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
    .ex_memwrite(ex_memwrite), .ex_MReg(ex_MReg),
`ifdef ID_EX_PERF_CNT_EN
    .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes),
`endif
    .stall_id(stall_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what EX should hold, in plain terms.
  logic m_valid, m_alusrc, m_regwrite, m_memwrite;
  logic [31:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [3:0] m_alu_op;
  logic [1:0] m_mreg;
  int unsigned m_lu_cnt, m_fl_cnt;

  function automatic logic model_haz();
    logic ex_is_load, needs;
    ex_is_load = m_valid && m_regwrite && (m_mreg == 2'd1) && (m_rd != 5'd0);
    needs = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
    return ex_is_load && id_valid && needs;
  endfunction

  task automatic model_reset();
    {m_valid, m_alusrc, m_regwrite, m_memwrite} = '0;
    {m_pc, m_rs1_data, m_rs2_data, m_imm} = '0;
    {m_rs1, m_rs2, m_rd, m_alu_op, m_mreg} = '0;
    m_lu_cnt = 0;
    m_fl_cnt = 0;
  endtask

  task automatic model_step();
    logic haz;
    haz = model_haz();
    if (hold) return;
    if (haz && !ex_flush) m_lu_cnt++;
    if (ex_flush) m_fl_cnt++;
    if (ex_flush || haz) begin
      m_valid = 0; m_regwrite = 0; m_memwrite = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_mreg = 2'd0;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data; m_imm = id_imm;
      m_alu_op = id_alu_op; m_alusrc = id_alusrc; m_mreg = id_MReg;
      m_regwrite = id_regwrite && id_valid;
      m_memwrite = id_memwrite && id_valid;
    end
  endtask

  task automatic check_outputs();
    check("ex_valid", ex_valid, m_valid);
    check("ex_regwrite", ex_regwrite, m_regwrite);
    check("ex_memwrite", ex_memwrite, m_memwrite);
    check("ex_rs1", ex_rs1, m_rs1);
    check("ex_rs2", ex_rs2, m_rs2);
    check("ex_rd", ex_rd, m_rd);
    check("ex_MReg", ex_MReg, m_mreg);
    // Datapath fields of a bubble are don't-care; compare them only for live instructions.
    if (m_valid) begin
      check("ex_pc", ex_pc, m_pc);
      check("ex_rs1_data", ex_rs1_data, m_rs1_data);
      check("ex_rs2_data", ex_rs2_data, m_rs2_data);
      check("ex_imm", ex_imm, m_imm);
      check("ex_alu_op", ex_alu_op, m_alu_op);
      check("ex_alusrc", ex_alusrc, m_alusrc);
    end
  endtask

  // Inputs are already driven; check the combinational stall, then clock once.
  task automatic cycle();
    #1;
    check("stall_id", stall_id, model_haz() && !ex_flush && !hold);
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic rw, input logic mw, input logic [1:0] sel);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_regwrite = rw; id_memwrite = mw;
    id_MReg = MReg_sel_e'(sel);
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_alu_op = 4'($urandom_range(0, 15)); id_alusrc = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1; hold = 0; ex_flush = 0;
    drive(1, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 2'd0);
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    check("reset_stall", stall_id, 1'b0);
    rst = 0;

    // Pass-through ADD x7, x5, x6.
    drive(1, 5'd5, 5'd6, 5'd7, 1, 1, 1, 0, 2'd0);
    id_rs1_data = 32'h10; id_rs2_data = 32'h20;
    cycle();
    check("add_rs1", ex_rs1, 5'd5);
    check("add_rd", ex_rd, 5'd7);
    check("add_rs2_data", ex_rs2_data, 32'h20);
    check("add_valid", ex_valid, 1'b1);

    // LW x3 then ADD x4, x3, x1.
    drive(1, 5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 2'd1);
    cycle();
    drive(1, 5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 2'd0);
    #1 check("lu_stall_on", stall_id, 1'b1);
    cycle();
    check("lu_bubble_valid", ex_valid, 1'b0);
    check("lu_bubble_rd", ex_rd, 5'd0);
    #1 check("lu_stall_off", stall_id, 1'b0);
    cycle();
    check("lu_add_rs1", ex_rs1, 5'd3);
    check("lu_add_valid", ex_valid, 1'b1);

    // LW x0 then use of x0: no stall.
    drive(1, 5'd1, 5'd0, 5'd0, 1, 0, 1, 0, 2'd1);
    cycle();
    drive(1, 5'd0, 5'd0, 5'd4, 1, 1, 1, 0, 2'd0);
    #1 check("x0_no_stall", stall_id, 1'b0);
    cycle();

    // LW x3 then I-type with unused rs2 = 3: no stall.
    drive(1, 5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 2'd1);
    cycle();
    drive(1, 5'd1, 5'd3, 5'd4, 1, 0, 1, 0, 2'd0);
    #1 check("itype_no_stall", stall_id, 1'b0);
    cycle();

    // Flush together with a hazard: no stall, bubble loaded.
    drive(1, 5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 2'd1);
    cycle();
    drive(1, 5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 2'd0);
    ex_flush = 1;
    #1 check("flush_no_stall", stall_id, 1'b0);
    cycle();
    check("flush_bubble", ex_valid, 1'b0);
    ex_flush = 0;

    // Hold + flush + hazard: EX contents frozen for two cycles.
    drive(1, 5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 2'd1);
    cycle();
    drive(1, 5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 2'd0);
    ex_flush = 1; hold = 1;
    cycle();
    cycle();
    check("hold_rd", ex_rd, 5'd3);
    check("hold_valid", ex_valid, 1'b1);
    ex_flush = 0; hold = 0;
    cycle();

    // Reset in the middle of a stall.
    drive(1, 5'd1, 5'd0, 5'd3, 1, 0, 1, 0, 2'd1);
    cycle();
    drive(1, 5'd3, 5'd1, 5'd4, 1, 1, 1, 0, 2'd0);
    #1 check("pre_rst_stall", stall_id, 1'b1);
    #2 rst = 1;
    #1 model_reset();
    check_outputs();
    check("rst_stall_drop", stall_id, 1'b0);
    @(posedge clk); #1;
    check_outputs();
    rst = 0;
    cycle();
    check("post_rst_load", ex_valid, 1'b1);
    check("post_rst_rd", ex_rd, 5'd4);

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
      hold     = ($urandom_range(0, 9) == 0);
      ex_flush = ($urandom_range(0, 9) == 0);
      cycle();
    end
    hold = 0; ex_flush = 0;

`ifdef ID_EX_PERF_CNT_EN
    check("perf_lu_stalls", perf_lu_stalls, 64'(m_lu_cnt));
    check("perf_flushes", perf_flushes, 64'(m_fl_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
